// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready handshake on both sides.
// Single-cycle ops (ADD, SUB, ANDB, XOR, SHL, SHR, BR) register their result
// on the accepting edge. MUL runs as a WIDTH-step shift-add sequence and
// blocks new requests while it runs.
// flags = {Z, N, V, C}.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    input  logic [1:0]       branch_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_val,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ANDB = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_BR   = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    // Shift amounts at or above this value flush the operand to zero.
    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);
    // Counter value on the cycle that performs the final multiply step.
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Registered state
    state_t                 state_q,     state_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       out_val_q,   out_val_d;
    logic [3:0]             flags_q,     flags_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [2*WIDTH-1:0]     acc_q,       acc_d;
    logic [2*WIDTH-1:0]     mcand_q,     mcand_d;
    logic [WIDTH-1:0]       mplier_q,    mplier_d;

    // Single-cycle datapath
    logic [WIDTH:0]         add_ext;
    logic [WIDTH:0]         sub_ext;
    logic                   add_v;
    logic                   sub_z;
    logic                   sub_n;
    logic                   sub_v;
    logic                   sub_c;
    logic                   br_bit;
    logic                   shift_big;
    logic [WIDTH-1:0]       alu_val;
    logic                   alu_v;
    logic                   alu_c;
    logic [3:0]             alu_flags;

    // Multiply step datapath
    logic [2*WIDTH-1:0]     step_acc;
    logic                   last_step;
    logic [3:0]             mul_flags;

    logic                   accept;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == ST_MUL);
    assign out_valid = out_valid_q;
    assign out_val   = out_val_q;
    assign flags     = flags_q;

    // Single-cycle ALU result and flags for the operation being presented
    always_comb begin
        add_ext   = {1'b0, in1} + {1'b0, in2};
        sub_ext   = {1'b0, in1} + {1'b0, ~in2} + (WIDTH+1)'(1);
        add_v     = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_ext[WIDTH-1] != in1[WIDTH-1]);
        sub_z     = (sub_ext[WIDTH-1:0] == '0);
        sub_n     = sub_ext[WIDTH-1];
        sub_v     = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_ext[WIDTH-1] != in1[WIDTH-1]);
        sub_c     = sub_ext[WIDTH];
        shift_big = (in2 >= SHIFT_LIMIT);
        alu_val   = '0;
        alu_v     = 1'b0;
        alu_c     = 1'b0;
        br_bit    = 1'b0;

        case (branch_sel)
            2'b00:   br_bit = sub_z;
            2'b01:   br_bit = sub_n;
            2'b10:   br_bit = sub_v;
            default: br_bit = sub_c;
        endcase

        case (op)
            OP_ADD: begin
                alu_val = add_ext[WIDTH-1:0];
                alu_v   = add_v;
                alu_c   = add_ext[WIDTH];
            end
            OP_SUB: begin
                alu_val = sub_ext[WIDTH-1:0];
                alu_v   = sub_v;
                alu_c   = sub_c;
            end
            OP_ANDB: alu_val = in1 & {WIDTH{in2[0]}};
            OP_XOR:  alu_val = in1 ^ in2;
            OP_SHL:  alu_val = shift_big ? '0 : (in1 << in2);
            OP_SHR:  alu_val = shift_big ? '0 : (in1 >> in2);
            OP_BR:   alu_val = {{(WIDTH-1){1'b0}}, br_bit};
            default: alu_val = '0;
        endcase

        // BR reports the flags of the difference, not of its 0/1 output.
        if (op == OP_BR) begin
            alu_flags = {sub_z, sub_n, sub_v, sub_c};
        end else begin
            alu_flags = {(alu_val == '0), alu_val[WIDTH-1], alu_v, alu_c};
        end
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        step_acc  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        last_step = (cnt_q == LAST_STEP);
        mul_flags = {(step_acc[WIDTH-1:0] == '0),
                     step_acc[WIDTH-1],
                     (step_acc[2*WIDTH-1:WIDTH] != '0),
                     1'b0};
    end

    // Next-state logic: handshake, op dispatch and multiply sequencing
    always_comb begin
        state_d     = state_q;
        out_val_d   = out_val_q;
        flags_d     = flags_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        // A held result drops once the consumer takes it; a new load below overrides.
        out_valid_d = out_valid_q && !out_ready;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d  = ST_MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, in1};
                        mplier_d = in2;
                    end else begin
                        out_valid_d = 1'b1;
                        out_val_d   = alu_val;
                        flags_d     = alu_flags;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = step_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_step) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    out_val_d   = step_acc[WIDTH-1:0];
                    flags_d     = mul_flags;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset clears everything at once, abandoning any multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_val_q   <= '0;
            flags_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_val_q   <= out_val_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: directed cases plus randomized traffic with
// backpressure. Expected results are queued when an op is accepted; a
// separate monitor pops and compares whenever a result is handed over.
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic [2:0]   op = '0;
    logic [1:0]   branch_sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_val;
    logic [3:0]   flags;
    logic         busy;

    alu_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in1        (in1),
        .in2        (in2),
        .op         (op),
        .branch_sel (branch_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_val    (out_val),
        .flags      (flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_q[$];     // {flags, value} in issue order
    bit          ov_m = 1'b0;  // model: a result is being presented
    int          mul_left = 0; // model: multiply edges still to go
    bit          in_reset = 1'b1;
    bit          s_ov, s_busy, s_ir;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour written directly from the arithmetic definitions.
    function automatic logic [11:0] ref_calc(input logic [2:0] o, input int a, input int b, input int sel);
        int  sa, sb, r, d;
        bit  z, n, v, c, dz, dn, dv, dc;
        longint p;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r = 0; v = 0; c = 0;
        d  = (a - b + 256) % 256;
        dz = (d == 0);
        dn = (d >= 128);
        dv = ((sa - sb) > 127) || ((sa - sb) < -128);
        dc = (a >= b);
        case (o)
            3'd0: begin
                r = (a + b) % 256;
                c = (a + b) >= 256;
                v = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            3'd1: begin r = d; c = dc; v = dv; end
            3'd2: r = (b % 2 == 1) ? a : 0;
            3'd3: r = a ^ b;
            3'd4: r = (b >= 8) ? 0 : ((a * (1 << b)) % 256);
            3'd5: r = (b >= 8) ? 0 : (a / (1 << b));
            3'd6: begin
                case (sel)
                    0: r = dz;
                    1: r = dn;
                    2: r = dv;
                    default: r = dc;
                endcase
                return {dz, dn, dv, dc, 8'(r)};
            end
            default: begin
                p = longint'(a) * longint'(b);
                r = int'(p % 256);
                v = (p >= 256);
            end
        endcase
        z = (r == 0);
        n = (r >= 128);
        return {z, n, v, c, 8'(r)};
    endfunction

    // One clock cycle of stimulus; checks handshake outputs against the cycle model.
    task automatic step(input bit v, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] sel, input bit ordy, output bit acc);
        bit exp_ir;
        @(negedge clk);
        in_valid   = v;
        op         = o;
        in1        = a;
        in2        = b;
        branch_sel = sel;
        out_ready  = ordy;
        #1;
        exp_ir = (mul_left == 0) && (!ov_m || ordy);
        s_ov   = out_valid;
        s_busy = busy;
        s_ir   = in_ready;
        check("in_ready", in_ready, exp_ir);
        check("out_valid", out_valid, ov_m);
        check("busy", busy, mul_left > 0);
        acc = v && exp_ir;
        if (acc) exp_q.push_back(ref_calc(o, a, b, sel));
        // Model update for the coming edge
        if (ov_m && ordy) ov_m = 1'b0;
        if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) ov_m = 1'b1;
        end
        if (acc) begin
            if (o == 3'b111) mul_left = W;
            else ov_m = 1'b1;
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] sel, input bit ordy, output int tries);
        bit acc;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 50) begin
            step(1'b1, o, a, b, sel, ordy, acc);
            tries++;
        end
        if (!acc) check("issue_timeout", 0, 1);
    endtask

    task automatic idle(input bit ordy);
        bit acc;
        step(1'b0, 3'b000, 8'h00, 8'h00, 2'b00, ordy, acc);
    endtask

    task automatic expect_out(input string name, input logic [7:0] val, input logic [3:0] fl);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_val"}, out_val, val);
        check({name, "_flags"}, flags, fl);
    endtask

    // Single-cycle op: result must be presented right after the accepting edge.
    task automatic single(input string name, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] sel, input logic [7:0] val, input logic [3:0] fl);
        int tries;
        issue(o, a, b, sel, 1'b1, tries);
        idle(1'b1);
        expect_out(name, val, fl);
    endtask

    task automatic mul_test(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] val, input logic [3:0] fl);
        int tries;
        int cnt;
        bit done;
        issue(3'b111, a, b, 2'b00, 1'b1, tries);
        cnt = 0;
        done = 1'b0;
        while (!done && cnt < 40) begin
            idle(1'b1);
            if (s_ov) begin
                done = 1'b1;
            end else begin
                check({name, "_busy"}, s_busy, 1);
                check({name, "_in_ready"}, s_ir, 0);
                cnt++;
            end
        end
        check({name, "_latency"}, cnt, W);
        expect_out(name, val, fl);
    endtask

    // Monitor: compare each handed-over result and check stability under backpressure.
    initial begin
        bit          hold;
        logic [7:0]  held_val;
        logic [3:0]  held_flags;
        logic [11:0] e;
        hold = 1'b0;
        held_val = '0;
        held_flags = '0;
        forever begin
            @(negedge clk);
            #3;
            if (in_reset) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_val", out_val, held_val);
                    check("hold_flags", flags, held_flags);
                end
                hold = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {flags, out_val}, e);
                        $display("result val=%02h flags=%04b | expected val=%02h flags=%04b",
                                 out_val, flags, e[7:0], e[11:8]);
                    end
                end else if (out_valid) begin
                    hold = 1'b1;
                    held_val = out_val;
                    held_flags = flags;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tries;
        bit acc;
        int guard;

        // Reset state, before any clock edge
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_val", out_val, 0);
        check("rst_flags", flags, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        in_reset = 1'b0;

        // Directed single-cycle ops
        single("add_7f_01", 3'b000, 8'h7F, 8'h01, 2'b00, 8'h80, 4'b0110);
        single("sub_05_05", 3'b001, 8'h05, 8'h05, 2'b00, 8'h00, 4'b1001);
        single("br_z",      3'b110, 8'h05, 8'h05, 2'b00, 8'h01, 4'b1001);
        single("br_c",      3'b110, 8'h03, 8'h05, 2'b11, 8'h00, 4'b0100);
        single("shl_by9",   3'b100, 8'h01, 8'h09, 2'b00, 8'h00, 4'b1000);
        single("shr_by7",   3'b101, 8'h80, 8'h07, 2'b00, 8'h01, 4'b0000);
        single("andb_1",    3'b010, 8'hA5, 8'h01, 2'b00, 8'hA5, 4'b0100);
        single("andb_2",    3'b010, 8'hA5, 8'h02, 2'b00, 8'h00, 4'b1000);

        // Multiply latency and flags
        mul_test("mul_0f_11", 8'h0F, 8'h11, 8'hFF, 4'b0100);
        mul_test("mul_10_10", 8'h10, 8'h10, 8'h00, 4'b1010);
        idle(1'b1);

        // Backpressure for 3 cycles with ignored requests, then 4 back-to-back XORs
        issue(3'b011, 8'h3C, 8'h5A, 2'b00, 1'b0, tries);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b000, 8'h11, 8'h22, 2'b00, 1'b0, acc);
            check("bp_in_ready", s_ir, 0);
        end
        for (int i = 0; i < 4; i++) begin
            issue(3'b011, 8'($urandom), 8'($urandom), 2'b00, 1'b1, tries);
            check("b2b_tries", tries, 1);
        end
        idle(1'b1);
        check("b2b_last_valid", s_ov, 1);
        idle(1'b1);

        // Reset in the middle of a multiply
        issue(3'b111, 8'h37, 8'h29, 2'b00, 1'b1, tries);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        in_reset = 1'b1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_out_val", out_val, 0);
        check("mrst_flags", flags, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        ov_m = 1'b0;
        mul_left = 0;
        in_reset = 1'b0;
        single("add_after_rst", 3'b000, 8'h02, 8'h03, 2'b00, 8'h05, 4'b0000);
        for (int i = 0; i < 12; i++) idle(1'b1);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            logic [2:0] ro;
            logic [7:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ((ro == 3'b100 || ro == 3'b101) && $urandom_range(0, 3) != 0)
                rb = 8'($urandom_range(0, 10));
            step($urandom_range(0, 99) < 70, ro, ra, rb, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 75, acc);
        end

        // Drain outstanding results
        guard = 0;
        while ((exp_q.size() != 0 || ov_m || mul_left > 0) && guard < 50) begin
            idle(1'b1);
            guard++;
        end
        idle(1'b1);
        check("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning datapath width in bits (legal range 4..32).
REQ-002 SHALL have derived localparam CNT_W, default $clog2(WIDTH)+1, meaning multiply step-counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation this cycle.
REQ-007 SHALL have port in1, in2  input  WIDTH each  operands.
REQ-008 SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 ANDB, 011 XOR, 100 SHL, 101 SHR, 110 BR, 111 MUL.
REQ-009 SHALL have port branch_sel  input  2  BR flag select: 00 zero, 01 sign, 10 overflow, 11 carry.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_val  output  WIDTH  result.
REQ-013 SHALL have port flags  output  4  {Z,N,V,C} captured with result.
REQ-014 SHALL have port busy  output  1  multiply in progress.

Function
REQ-015 SHALL accept an operation on any rising edge with in_valid && in_ready, capturing in1, in2, op, branch_sel.
REQ-016 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready), combinationally.
REQ-017 SHALL implement FSM states IDLE and MUL; IDLE->MUL on accepted op=111; MUL->IDLE on the edge completing the last step; all other ops stay in IDLE.
REQ-018 Non-MUL ops SHALL register out_val/flags and set out_valid on the accepting edge (latency 1, throughput 1 per cycle).
REQ-019 ADD/SUB SHALL compute in1 + in2 / in1 + ~in2 + 1, modulo 2^WIDTH; C = carry out (SUB: C=1 means no borrow); V = signed overflow.
REQ-020 ANDB SHALL produce in1 & {WIDTH{in2[0]}}; XOR SHALL produce in1 ^ in2; both SHALL give V=C=0.
REQ-021 SHL/SHR SHALL be logical shifts of in1 by unsigned in2; in2 >= WIDTH SHALL give 0; V=C=0.
REQ-022 BR SHALL compute in1 - in2, select Z/N/V/C of that difference per branch_sel, and output it zero-extended to WIDTH; flags SHALL be those of the difference.
REQ-023 MUL SHALL be iterative shift-add, one multiplier bit per cycle, WIDTH steps; out_valid rises exactly WIDTH edges after the accepting edge.
REQ-024 MUL out_val SHALL be product[WIDTH-1:0]; V = (product[2*WIDTH-1:WIDTH] != 0); C=0.
REQ-025 For all ops Z = (out_val==0) and N = out_val[WIDTH-1], except BR (REQ-022).
REQ-026 busy SHALL be 1 exactly while state==MUL; in_ready SHALL be 0 while busy.
REQ-027 While out_valid && !out_ready, out_val and flags SHALL hold stable; out_valid SHALL clear on out_ready unless a new result loads on the same edge.
REQ-028 A MUL result completing while the previous result is unaccepted SHALL NOT occur: MUL accept requires out_valid clear or being consumed (REQ-016), and out_valid is low during MUL.
REQ-029 Ops arriving with in_ready=0 SHALL be ignored; no internal queuing.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, out_valid=0, out_val=0, flags=0, busy=0, step counter=0, regardless of clk.
REQ-031 Reset during MUL SHALL abandon the operation with no result produced; first edge after release behaves as from IDLE.

Verification
REQ-032 ADD 8'h7F+8'h01 -> one cycle later out_val=8'h80, flags Z0 N1 V1 C0.
REQ-033 SUB 8'h05-8'h05 -> 8'h00, Z1 C1; BR same operands sel=00 -> 8'h01; BR 8'h03,8'h05 sel=11 -> 8'h00.
REQ-034 MUL 8'h0F*8'h11 -> 8'hFF, V0, out_valid exactly 8 edges after accept, busy=1 and in_ready=0 throughout; MUL 8'h10*8'h10 -> 8'h00, Z1 V1.
REQ-035 out_ready=0 for 3 cycles after a result -> out_val/flags unchanged, in_ready=0; then 4 back-to-back XORs with out_ready=1 -> 4 results on 4 consecutive cycles.
REQ-036 rst_n pulsed low at MUL step 3 -> out_valid=0, busy=0 immediately; after release, in_ready=1 and ADD 8'h02+8'h03 -> 8'h05.
REQ-037 SHL 8'h01 by 9 -> 8'h00, Z1; SHR 8'h80 by 7 -> 8'h01; ANDB 8'hA5 with in2=8'h01 -> 8'hA5, with in2=8'h02 -> 8'h00.
